// File: rtl/ex_mem_stage_if.sv
// EX/M pipeline-register bundle: EX-stage fields, WB forwarding source, stall/flush
// control and the registered M-stage outputs with their memory strobes.
interface ex_mem_stage_if;
   logic        stall;
   logic        flush;
   logic [31:0] E_instr;
   logic [31:0] E_pc;
   logic [31:0] E_alu_res;
   logic [31:0] E_rt_data;
   logic [4:0]  E_wreg;
   logic        E_regwrite;
   logic        E_valid;
   logic [4:0]  W_wreg;
   logic        W_regwrite;
   logic [31:0] W_wdata;
   logic [31:0] M_instr;
   logic [31:0] M_pc;
   logic [31:0] M_mem_addr;
   logic [31:0] M_mem_data;
   logic [4:0]  M_wreg;
   logic        M_regwrite;
   logic        M_valid;
   logic        M_sw_p;
   logic        M_lw_p;
   logic        M_we;
   logic        M_adel;
   logic        M_ades;

   modport master (
      output stall, flush, E_instr, E_pc, E_alu_res, E_rt_data, E_wreg, E_regwrite,
             E_valid, W_wreg, W_regwrite, W_wdata,
      input  M_instr, M_pc, M_mem_addr, M_mem_data, M_wreg, M_regwrite, M_valid,
             M_sw_p, M_lw_p, M_we, M_adel, M_ades
   );

   modport slave (
      input  stall, flush, E_instr, E_pc, E_alu_res, E_rt_data, E_wreg, E_regwrite,
             E_valid, W_wreg, W_regwrite, W_wdata,
      output M_instr, M_pc, M_mem_addr, M_mem_data, M_wreg, M_regwrite, M_valid,
             M_sw_p, M_lw_p, M_we, M_adel, M_ades
   );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/M pipeline register with store-data forwarding and memory strobe decode.
// Define EXMEM_ADDR_CHECK_EN to enable misalignment / out-of-range address flags.
module ex_mem_stage #(
   parameter int          DM_ADDR_BITS = 16,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
   input logic          clk,
   input logic          rst,
   ex_mem_stage_if.slave bus
);

   logic [31:0] instr_r;
   logic [31:0] pc_r;
   logic [31:0] addr_r;
   logic [31:0] data_r;
   logic [4:0]  wreg_r;
   logic        regwrite_r;
   logic        valid_r;

   logic        fwd_cap_s;
   logic        fwd_hold_s;
   logic [5:0]  opcode_s;
   logic        is_load_s;
   logic        is_store_s;
   logic        size_word_s;
   logic        size_half_s;
   logic        misalign_s;
   logic        range_s;
   logic        addr_err_s;
   logic        bad_s;
   logic        adel_s;

   function automatic logic is_load_f(input logic [5:0] op);
      case (op)
         6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011: is_load_f = 1'b1;
         default:                                               is_load_f = 1'b0;
      endcase
   endfunction

   function automatic logic is_store_f(input logic [5:0] op);
      case (op)
         6'b101000, 6'b101001, 6'b101011: is_store_f = 1'b1;
         default:                         is_store_f = 1'b0;
      endcase
   endfunction

   // WB result overrides rt data whenever WB writes the store's source register
   always_comb begin
      fwd_cap_s  = bus.W_regwrite && (bus.W_wreg != 5'd0) && (bus.W_wreg == bus.E_instr[20:16]);
      fwd_hold_s = bus.W_regwrite && (bus.W_wreg != 5'd0) && (bus.W_wreg == instr_r[20:16]);
   end

   // Pipeline register: reset/flush bubble, stall hold with data refresh, or capture
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         instr_r    <= NOP_INSTR;
         pc_r       <= 32'h0000_0000;
         addr_r     <= 32'h0000_0000;
         data_r     <= 32'h0000_0000;
         wreg_r     <= 5'd0;
         regwrite_r <= 1'b0;
         valid_r    <= 1'b0;
      end else if (bus.stall) begin
         if (fwd_hold_s) begin
            data_r <= bus.W_wdata;
         end
      end else begin
         instr_r    <= bus.E_instr;
         pc_r       <= bus.E_pc;
         addr_r     <= bus.E_alu_res;
         data_r     <= fwd_cap_s ? bus.W_wdata : bus.E_rt_data;
         wreg_r     <= bus.E_wreg;
         regwrite_r <= bus.E_regwrite;
         valid_r    <= bus.E_valid;
      end
   end

   // Opcode decode and access-size classification of the held instruction
   always_comb begin
      opcode_s    = instr_r[31:26];
      is_load_s   = is_load_f(opcode_s);
      is_store_s  = is_store_f(opcode_s);
      size_word_s = 1'b0;
      size_half_s = 1'b0;
      case (opcode_s)
         6'b100011, 6'b101011:            size_word_s = 1'b1;
         6'b100001, 6'b100101, 6'b101001: size_half_s = 1'b1;
         default: begin
            size_word_s = 1'b0;
            size_half_s = 1'b0;
         end
      endcase
   end

   // Address error detection; the disabled build keeps the check logic but masks it
   always_comb begin
      if (size_word_s) begin
         misalign_s = |addr_r[1:0];
      end else if (size_half_s) begin
         misalign_s = addr_r[0];
      end else begin
         misalign_s = 1'b0;
      end
      range_s    = |addr_r[31:DM_ADDR_BITS];
      addr_err_s = misalign_s | range_s;
`ifdef EXMEM_ADDR_CHECK_EN
      bad_s      = addr_err_s;
`else
      bad_s      = addr_err_s & 1'b0;
`endif
   end

   // Strobes and flags derive only from registered fields; a bubble asserts nothing
   always_comb begin
      adel_s          = valid_r & is_load_s & bad_s;
      bus.M_instr     = instr_r;
      bus.M_pc        = pc_r;
      bus.M_mem_addr  = addr_r;
      bus.M_mem_data  = data_r;
      bus.M_wreg      = wreg_r;
      bus.M_valid     = valid_r;
      bus.M_lw_p      = valid_r & is_load_s & ~bad_s;
      bus.M_sw_p      = valid_r & is_store_s & ~bad_s;
      bus.M_we        = valid_r & is_store_s & ~bad_s;
      bus.M_adel      = adel_s;
      bus.M_ades      = valid_r & is_store_s & bad_s;
      bus.M_regwrite  = valid_r & regwrite_r & ~adel_s;
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table plus stall/flush/reset sequences.
// Expected flags follow EXMEM_ADDR_CHECK_EN when defined for the build.
module tb_ex_mem_stage;

   logic clk;
   logic rst;
   ex_mem_stage_if bus ();

   ex_mem_stage #(.DM_ADDR_BITS(16), .NOP_INSTR(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags = {regwrite, lw_p, sw_p, adel, ades}
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] rt;
      logic [4:0]  wreg;
      logic        rw;
      logic        valid;
      logic [4:0]  w_wreg;
      logic        w_rw;
      logic [31:0] w_wdata;
      logic [31:0] exp_data;
      logic [4:0]  f_chk;
      logic [4:0]  f_nochk;
   } vec_t;

   vec_t vq[$];
   int   n_vec;
   int   n_err;

   localparam logic [5:0] OP_LB = 6'b100000, OP_LBU = 6'b100100, OP_LH = 6'b100001,
                          OP_LHU = 6'b100101, OP_LW = 6'b100011, OP_SB = 6'b101000,
                          OP_SH = 6'b101001, OP_SW = 6'b101011, OP_RT = 6'b000000;

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
      mk = {op, 5'd1, rt, imm};
   endfunction

   task automatic add(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] addr,
                      input logic [31:0] rt, input logic [4:0] wreg, input logic rw, input logic valid,
                      input logic [4:0] w_wreg, input logic w_rw, input logic [31:0] w_wdata,
                      input logic [31:0] exp_data, input logic [4:0] f_chk, input logic [4:0] f_nochk);
      vec_t v;
      v.instr = instr; v.pc = pc; v.addr = addr; v.rt = rt; v.wreg = wreg; v.rw = rw;
      v.valid = valid; v.w_wreg = w_wreg; v.w_rw = w_rw; v.w_wdata = w_wdata;
      v.exp_data = exp_data; v.f_chk = f_chk; v.f_nochk = f_nochk;
      vq.push_back(v);
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [4:0] wreg, input logic rw, input logic valid,
                        input logic [4:0] w_wreg, input logic w_rw, input logic [31:0] w_wdata);
      bus.E_instr = instr; bus.E_pc = pc; bus.E_alu_res = addr; bus.E_rt_data = rt;
      bus.E_wreg = wreg; bus.E_regwrite = rw; bus.E_valid = valid;
      bus.W_wreg = w_wreg; bus.W_regwrite = w_rw; bus.W_wdata = w_wdata;
   endtask

   function automatic logic [4:0] pick(input logic [4:0] f_chk, input logic [4:0] f_nochk);
`ifdef EXMEM_ADDR_CHECK_EN
      pick = f_chk;
`else
      pick = f_nochk;
`endif
   endfunction

   function automatic logic [139:0] expv(input logic [31:0] instr, input logic [31:0] pc,
                                         input logic [31:0] addr, input logic [31:0] data,
                                         input logic [4:0] wreg, input logic valid, input logic [4:0] f);
      expv = {instr, pc, addr, data, wreg, valid, f, f[2]};
   endfunction

   function automatic logic [139:0] actv();
      actv = {bus.M_instr, bus.M_pc, bus.M_mem_addr, bus.M_mem_data, bus.M_wreg, bus.M_valid,
              bus.M_regwrite, bus.M_lw_p, bus.M_sw_p, bus.M_adel, bus.M_ades, bus.M_we};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [139:0] exp);
      logic [139:0] act;
      act = actv();
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;

      // Table: {instr, pc, addr, rt, wreg, rw, valid, w_wreg, w_rw, w_wdata, exp_data, f_chk, f_nochk}
      add(mk(OP_SW, 5'd9, 16'h0010), 32'h3000, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1,
          5'd0, 1'b0, 32'h0, 32'hDEADBEEF, 5'b00100, 5'b00100);
      add(mk(OP_SB, 5'd8, 16'h0021), 32'h3004, 32'h21, 32'h11111111, 5'd0, 1'b0, 1'b1,
          5'd8, 1'b1, 32'h55, 32'h00000055, 5'b00100, 5'b00100);
      add(mk(OP_SB, 5'd8, 16'h0022), 32'h3008, 32'h22, 32'h22222222, 5'd0, 1'b0, 1'b1,
          5'd0, 1'b1, 32'h55, 32'h22222222, 5'b00100, 5'b00100);
      add(mk(OP_SB, 5'd0, 16'h0023), 32'h300C, 32'h23, 32'h33333333, 5'd0, 1'b0, 1'b1,
          5'd0, 1'b1, 32'h99, 32'h33333333, 5'b00100, 5'b00100);
      add(mk(OP_SW, 5'd8, 16'h0024), 32'h3010, 32'h24, 32'h44444444, 5'd0, 1'b0, 1'b1,
          5'd8, 1'b0, 32'h77, 32'h44444444, 5'b00100, 5'b00100);
      add(mk(OP_LH, 5'd5, 16'h0003), 32'h3014, 32'h3, 32'h5, 5'd5, 1'b1, 1'b1,
          5'd0, 1'b0, 32'h0, 32'h5, 5'b00010, 5'b11000);
      add(mk(OP_SW, 5'd6, 16'h0002), 32'h3018, 32'h2, 32'h6, 5'd0, 1'b0, 1'b1,
          5'd0, 1'b0, 32'h0, 32'h6, 5'b00001, 5'b00100);
      add(mk(OP_LB, 5'd6, 16'h0003), 32'h301C, 32'h3, 32'h7, 5'd6, 1'b1, 1'b1,
          5'd0, 1'b0, 32'h0, 32'h7, 5'b11000, 5'b11000);
      add(mk(OP_SW, 5'd2, 16'h0000), 32'h3020, 32'h0001_0000, 32'h8, 5'd0, 1'b0, 1'b1,
          5'd0, 1'b0, 32'h0, 32'h8, 5'b00001, 5'b00100);
      add(mk(OP_LW, 5'd4, 16'hFFFC), 32'h3024, 32'h0000_FFFC, 32'h9, 5'd4, 1'b1, 1'b1,
          5'd0, 1'b0, 32'h0, 32'h9, 5'b11000, 5'b11000);
      add(mk(OP_LHU, 5'd4, 16'h0002), 32'h3028, 32'h2, 32'hA, 5'd4, 1'b1, 1'b1,
          5'd0, 1'b0, 32'h0, 32'hA, 5'b11000, 5'b11000);
      add(mk(OP_SH, 5'd3, 16'h0001), 32'h302C, 32'h1, 32'hB, 5'd0, 1'b0, 1'b1,
          5'd0, 1'b0, 32'h0, 32'hB, 5'b00001, 5'b00100);
      add(mk(OP_RT, 5'd3, 16'h1821), 32'h3030, 32'h3, 32'hC, 5'd3, 1'b1, 1'b1,
          5'd0, 1'b0, 32'h0, 32'hC, 5'b10000, 5'b10000);
      add(mk(OP_SW, 5'd3, 16'h0010), 32'h3034, 32'h10, 32'hD, 5'd3, 1'b1, 1'b0,
          5'd0, 1'b0, 32'h0, 32'hD, 5'b00000, 5'b00000);
      add(mk(OP_LW, 5'd4, 16'h0000), 32'h3038, 32'h8000_0000, 32'hE, 5'd4, 1'b1, 1'b1,
          5'd0, 1'b0, 32'h0, 32'hE, 5'b00010, 5'b11000);
      add(mk(OP_LBU, 5'd4, 16'h0001), 32'h303C, 32'h0000_FFFF, 32'hF, 5'd4, 1'b1, 1'b1,
          5'd0, 1'b0, 32'h0, 32'hF, 5'b11000, 5'b11000);

      // Reset with a valid store sitting in EX
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      rst = 1'b1;
      drive(mk(OP_SW, 5'd9, 16'h0010), 32'h3000, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1,
            5'd0, 1'b0, 32'h0);
      step();
      chk("reset_c1", 140'd0);
      step();
      chk("reset_c2", 140'd0);
      rst = 1'b0;

      foreach (vq[i]) begin
         drive(vq[i].instr, vq[i].pc, vq[i].addr, vq[i].rt, vq[i].wreg, vq[i].rw, vq[i].valid,
               vq[i].w_wreg, vq[i].w_rw, vq[i].w_wdata);
         step();
         chk($sformatf("vec%0d", i),
             expv(vq[i].instr, vq[i].pc, vq[i].addr, vq[i].exp_data, vq[i].wreg, vq[i].valid,
                  pick(vq[i].f_chk, vq[i].f_nochk)));
      end

      // Stall refresh on a held LW, then flush beats stall
      drive(mk(OP_LW, 5'd7, 16'h0040), 32'h4000, 32'h40, 32'hAAAA_0000, 5'd7, 1'b1, 1'b1,
            5'd0, 1'b0, 32'h0);
      step();
      chk("lw_load", expv(mk(OP_LW, 5'd7, 16'h0040), 32'h4000, 32'h40, 32'hAAAA_0000, 5'd7, 1'b1, 5'b11000));
      bus.stall = 1'b1;
      drive(mk(OP_SW, 5'd2, 16'h0000), 32'h5000, 32'h99, 32'hBBBB_BBBB, 5'd2, 1'b0, 1'b1,
            5'd7, 1'b1, 32'h1234);
      step();
      chk("stall_refresh", expv(mk(OP_LW, 5'd7, 16'h0040), 32'h4000, 32'h40, 32'h1234, 5'd7, 1'b1, 5'b11000));
      bus.W_wreg = 5'd9;
      bus.W_wdata = 32'hFFFF;
      step();
      chk("stall_hold", expv(mk(OP_LW, 5'd7, 16'h0040), 32'h4000, 32'h40, 32'h1234, 5'd7, 1'b1, 5'b11000));
      bus.flush = 1'b1;
      step();
      chk("flush_stall", 140'd0);
      bus.flush = 1'b0;
      bus.stall = 1'b0;

      // Reset in the middle of a stalled store
      drive(mk(OP_SW, 5'd9, 16'h0008), 32'h6000, 32'h8, 32'hCAFE, 5'd0, 1'b0, 1'b1,
            5'd0, 1'b0, 32'h0);
      step();
      chk("sw_load", expv(mk(OP_SW, 5'd9, 16'h0008), 32'h6000, 32'h8, 32'hCAFE, 5'd0, 1'b1, 5'b00100));
      bus.stall = 1'b1;
      rst = 1'b1;
      step();
      chk("rst_stalled", 140'd0);
      rst = 1'b0;
      step();
      chk("post_rst_stall", 140'd0);
      bus.stall = 1'b0;

      // Flush alone then normal capture resumes
      drive(mk(OP_LW, 5'd5, 16'h0020), 32'h7000, 32'h20, 32'h1357, 5'd5, 1'b1, 1'b1,
            5'd0, 1'b0, 32'h0);
      bus.flush = 1'b1;
      step();
      chk("flush_only", 140'd0);
      bus.flush = 1'b0;
      step();
      chk("after_flush", expv(mk(OP_LW, 5'd5, 16'h0020), 32'h7000, 32'h20, 32'h1357, 5'd5, 1'b1, 5'b11000));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Pipeline register between Execute and the data-memory stage of the 5-stage MIPS pipeline. Captures the EX-stage instruction, PC, effective address, store data and write-back destination once per cycle. Applies stall/flush control and forwards late write-back results into held store data. Decodes the captured opcode into the store/load strobes and write enable that the data memory consumes, and flags misaligned or out-of-range accesses.

Parameters:
DM_ADDR_BITS, 16, byte-address width backed by data memory; any higher address bit set means out of range.
NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  hold all M-stage registers
flush  in  1  load a bubble into M stage
E_instr  in  32  EX-stage instruction
E_pc  in  32  EX-stage PC
E_alu_res  in  32  effective address / ALU result
E_rt_data  in  32  rt value read in EX (store data)
E_wreg  in  5  destination register
E_regwrite  in  1  instruction writes the register file
E_valid  in  1  EX slot holds a real instruction
W_wreg  in  5  WB-stage destination
W_regwrite  in  1  WB-stage write enable
W_wdata  in  32  WB-stage write data
M_instr  out  32  registered instruction (to DM INSTR)
M_pc  out  32  registered PC
M_mem_addr  out  32  registered address (to DM MemAddr)
M_mem_data  out  32  registered/forwarded store data (to DM MemData)
M_wreg  out  5  registered destination
M_regwrite  out  1  gated register write enable
M_valid  out  1  M slot valid
M_sw_p  out  1  store strobe
M_lw_p  out  1  load strobe
M_we  out  1  memory write enable (equals M_sw_p)
M_adel  out  1  load address error
M_ades  out  1  store address error

Behaviour:
- Registers update on posedge clk. Priority: rst > flush > stall > normal capture.
- rst or flush: M_instr=NOP_INSTR, all other registers 0. Every output is then 0.
- flush with stall in the same cycle: flush wins and a bubble is loaded.
- stall alone: all registers hold, except the store-data refresh described below.
- Normal capture: load every E_* field into its matching register. Latency from EX to M outputs is 1 cycle.
- Capture forwarding: if W_regwrite && W_wreg!=0 && W_wreg==E_instr[20:16], capture W_wdata into M_mem_data. Otherwise capture E_rt_data.
- Stall refresh: while stall=1 and flush=0, if W_regwrite && W_wreg!=0 && W_wreg==M_instr[20:16], load W_wdata into M_mem_data.
- Opcode decode uses M_instr[31:26]:
  - loads: LB 100000, LBU 100100, LH 100001, LHU 100101, LW 100011
  - stores: SB 101000, SH 101001, SW 101011
- Misalignment:
  - word access (LW/SW) is misaligned when addr[1:0]!=0.
  - half access (LH/LHU/SH) is misaligned when addr[0]!=0.
  - byte accesses are never misaligned.
- Out of range: any bit of M_mem_addr[31:DM_ADDR_BITS] is 1.
- bad = misaligned or out of range.
- Strobes and flags are combinational from the registered fields only:
  - M_lw_p = M_valid & is_load & ~bad
  - M_sw_p = M_we = M_valid & is_store & ~bad
  - M_adel = M_valid & is_load & bad
  - M_ades = M_valid & is_store & bad
  - M_regwrite = registered regwrite & ~M_adel
- Non-memory instructions pass through with all strobes and flags 0.
- A bubble (M_valid=0) never asserts a strobe, regwrite or flag.
- Reset takes effect even in the middle of a stalled store. No strobe is asserted in the cycle after reset.

Optional Feature:
- Macro: EXMEM_ADDR_CHECK_EN.
- Defined: misalignment and range checks behave as in Behaviour.
- Undefined: bad is forced to 0, and M_adel and M_ades are tied to 0.
  - Strobes become M_valid & is_load and M_valid & is_store.
  - M_regwrite equals the registered value.

Test Plan:
- Reset: rst=1 for 2 cycles with E_valid=1 and SW in EX -> every output 0 and M_instr=0 in the cycle after reset.
- Basic capture: SW at E_pc=0x3000, addr 0x10, rt data 0xDEADBEEF, W_regwrite=0 -> next cycle M_mem_addr=0x10, M_mem_data=0xDEADBEEF, M_sw_p=M_we=1, M_lw_p=0.
- Capture forwarding: SB with rt=$8 while W_wreg=8, W_regwrite=1, W_wdata=0x55 -> M_mem_data=0x55. Repeat with W_wreg=0 -> E_rt_data is captured.
- Stall refresh: LW held in M with stall=1; W writes M's rt with 0x1234 -> M_mem_data=0x1234 while all other fields are unchanged. Then flush=1 together with stall=1 -> bubble, all strobes 0.
- Misaligned access, macro defined: LH at addr 0x3 -> M_adel=1, M_lw_p=0, M_regwrite=0. SW at 0x2 -> M_ades=1, M_we=0. LB at 0x3 -> M_lw_p=1, no flag.
- Out of range: SW at 0x0001_0000 -> M_ades=1 with the macro defined. With the macro undefined -> M_sw_p=1 and M_ades=0.
